debounce_multi: RTL and testbench

Parametrised multi-channel successor to the single-bit shift-register debouncer. Each channel synchronises a raw switch or button input, then qualifies every level change with a run-time-programmable stability count. Each channel outputs a debounced level plus single-cycle rise and fall pulses. It sits between board-level inputs and the control logic that consumes clean levels and edge events.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_ch.sv | 115 +++++++++++
 rtl/debounce_multi.sv | 52 +++++
 tb/tb_debounce_multi.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel debouncer.
//   db_state_e : per-channel state, encoded as {debounced level, counter non-zero}
//   SYNC_MIN/SYNC_MAX : legal range for the synchroniser depth
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } db_state_e;

    localparam int unsigned SYNC_MIN = 2;
    localparam int unsigned SYNC_MAX = 4;

    // The state is never stored on its own; it is recovered from the level and counter.
    function automatic db_state_e enc_state(input logic level, input logic pending);
        return db_state_e'({level, pending});
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: synchroniser chain, stability counter, state machine, edge pulses.
// Ports:
//   clk, reset_n  : clock and asynchronous active-low reset
//   switch_in     : raw asynchronous input bit
//   thr           : stability threshold, already clamped to >= 1 by the parent
//   switch_out    : debounced level (registered)
//   rise, fall    : registered single-cycle pulses on switch_out 0->1 / 1->0
//   busy          : a candidate change is pending (counter non-zero)
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        INIT_BIT    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             switch_in,
    input  logic [CNT_W-1:0] thr,
    output logic             switch_out,
    output logic             rise,
    output logic             fall,
    output logic             busy
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    logic                   s;
    logic                   at_thr;
    db_state_e              state;

    assign s      = sync_q[SYNC_STAGES-1];
    assign state  = enc_state(out_q, cnt_q != '0);
    // cnt_q counts mismatches already seen; this cycle's mismatch is number cnt_q+1.
    // >= (not ==) lets a lowered threshold commit on the next mismatch cycle.
    assign at_thr = (cnt_q >= (thr - CNT_W'(1)));

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], switch_in};
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;

        unique case (state)
            STABLE_LO: begin
                if (s) begin
                    if (at_thr) begin
                        out_d  = 1'b1;
                        rise_d = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            PEND_HI: begin
                // A low sample drops the candidate; cnt_d stays 0.
                if (s) begin
                    if (at_thr) begin
                        out_d  = 1'b1;
                        rise_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (at_thr) begin
                        out_d  = 1'b0;
                        fall_d = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            PEND_LO: begin
                if (!s) begin
                    if (at_thr) begin
                        out_d  = 1'b0;
                        fall_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{INIT_BIT}};
            cnt_q  <= '0;
            out_q  <= INIT_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign switch_out = out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign busy       = (cnt_q != '0);

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: N_CH independent channels sharing one stability threshold.
// Ports:
//   clk, reset_n  : clock and asynchronous active-low reset
//   switch_in     : raw asynchronous inputs, one bit per channel
//   stable_cycles : consecutive mismatch cycles needed to accept a change (0 behaves as 1)
//   switch_out    : debounced levels
//   rise, fall    : single-cycle pulses on debounced 0->1 / 1->0 transitions
//   busy          : per-channel candidate change pending
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned     N_CH        = 4,
    parameter int unsigned     CNT_W       = 16,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter logic [N_CH-1:0] INIT_VAL    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  switch_in,
    input  logic [CNT_W-1:0] stable_cycles,
    output logic [N_CH-1:0]  switch_out,
    output logic [N_CH-1:0]  rise,
    output logic [N_CH-1:0]  fall,
    output logic [N_CH-1:0]  busy
);

    if ((SYNC_STAGES < SYNC_MIN) || (SYNC_STAGES > SYNC_MAX)) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be within 2..4");
    end

    logic [CNT_W-1:0] thr;

    assign thr = (stable_cycles == '0) ? CNT_W'(1) : stable_cycles;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_ch #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .INIT_BIT   (INIT_VAL[ch])
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .switch_in (switch_in[ch]),
            .thr       (thr),
            .switch_out(switch_out[ch]),
            .rise      (rise[ch]),
            .fall      (fall[ch]),
            .busy      (busy[ch])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

    localparam int          N_CH = 4;
    localparam int          CNT_W = 16;
    localparam int          SYNC = 2;
    localparam logic [3:0]  INIT = 4'b0101;

    logic             clk;
    logic             reset_n;
    logic [3:0]       switch_in;
    logic [15:0]      stable_cycles;
    logic [3:0]       switch_out, rise, fall, busy;

    int n_checks = 0;
    int n_fail   = 0;

    debounce_multi #(
        .N_CH       (N_CH),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC),
        .INIT_VAL   (INIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .switch_in    (switch_in),
        .stable_cycles(stable_cycles),
        .switch_out   (switch_out),
        .rise         (rise),
        .fall         (fall),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the synchroniser is a delay line of whole input vectors, and each
    // channel counts consecutive cycles its synced input disagrees with its output; the
    // output flips once that run reaches the threshold.
    logic [3:0] m_hist[$];
    logic [3:0] m_out, m_rise, m_fall;
    int         m_run[N_CH];

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(INIT);
        m_out  = INIT;
        m_rise = '0;
        m_fall = '0;
        for (int ch = 0; ch < N_CH; ch++) m_run[ch] = 0;
    endtask

    task automatic model_step();
        logic [3:0] s_vec;
        int         thr;
        s_vec = m_hist[$];
        thr   = (stable_cycles == 0) ? 1 : int'(stable_cycles);
        for (int ch = 0; ch < N_CH; ch++) begin
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            if (s_vec[ch] != m_out[ch]) begin
                m_run[ch]++;
                if (m_run[ch] >= thr) begin
                    m_out[ch]  = s_vec[ch];
                    m_rise[ch] = s_vec[ch];
                    m_fall[ch] = ~s_vec[ch];
                    m_run[ch]  = 0;
                end
            end else begin
                m_run[ch] = 0;
            end
        end
        m_hist.push_front(switch_in);
        void'(m_hist.pop_back());
    endtask

    function automatic logic [3:0] m_busy();
        logic [3:0] b;
        for (int ch = 0; ch < N_CH; ch++) b[ch] = (m_run[ch] != 0);
        return b;
    endfunction

    // One clock with the model in lock-step; inputs change only on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("model", {switch_out, rise, fall, busy}, {m_out, m_rise, m_fall, m_busy()});
        check("rise_fall_excl", 32'(rise & fall), 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all(input string name, input logic [3:0] e_out, input logic [3:0] e_rise,
                             input logic [3:0] e_fall, input logic [3:0] e_busy);
        check({name, " out"},  32'(switch_out), 32'(e_out));
        check({name, " rise"}, 32'(rise),       32'(e_rise));
        check({name, " fall"}, 32'(fall),       32'(e_fall));
        check({name, " busy"}, 32'(busy),       32'(e_busy));
    endtask

    typedef struct {
        logic [3:0]  sw;
        logic [15:0] sc;
        int          hold;
        logic [3:0]  e_out;
        logic [3:0]  e_rise;
        logic [3:0]  e_fall;
        logic [3:0]  e_busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Each row: drive sw/sc, wait 'hold' clocks (first one samples), then compare.
        tbl[0]  = '{4'b0101, 16'd3, 20, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0111, 16'd3,  4, 4'b0101, 4'b0000, 4'b0000, 4'b0010};
        tbl[2]  = '{4'b0111, 16'd3,  1, 4'b0111, 4'b0010, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0111, 16'd3,  1, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0110, 16'd1,  2, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0110, 16'd1,  1, 4'b0110, 4'b0000, 4'b0001, 4'b0000};
        tbl[6]  = '{4'b1001, 16'd0,  3, 4'b1001, 4'b1001, 4'b0110, 4'b0000};
        tbl[7]  = '{4'b1001, 16'd0,  1, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0001, 16'd4,  3, 4'b1001, 4'b0000, 4'b0000, 4'b1000};
        tbl[9]  = '{4'b1001, 16'd4,  2, 4'b1001, 4'b0000, 4'b0000, 4'b1000};
        tbl[10] = '{4'b1001, 16'd4,  1, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{4'b1001, 16'd4, 10, 4'b1001, 4'b0000, 4'b0000, 4'b0000};

        // Reset and idle
        reset_n       = 1'b0;
        switch_in     = INIT;
        stable_cycles = 16'd3;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_all("in_reset", INIT, 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            switch_in     = tbl[i].sw;
            stable_cycles = tbl[i].sc;
            ticks(tbl[i].hold);
            check_all($sformatf("row%0d", i), tbl[i].e_out, tbl[i].e_rise, tbl[i].e_fall,
                      tbl[i].e_busy);
        end

        // Clean step, thr=8: commit on the 10th edge, busy for the 7 cycles before it.
        switch_in     = 4'b1011;
        stable_cycles = 16'd8;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("step k%0d out1", k),  32'(switch_out[1]), 32'(k >= 10));
            check($sformatf("step k%0d rise1", k), 32'(rise[1]),       32'(k == 10));
            check($sformatf("step k%0d busy1", k), 32'(busy[1]),       32'(k >= 3 && k <= 9));
        end

        // Lowering the threshold from 100 to 5 with 20 mismatches counted.
        switch_in     = 4'b1111;
        stable_cycles = 16'd100;
        ticks(22);
        check_all("lower_pre", 4'b1011, 4'b0000, 4'b0000, 4'b0100);
        stable_cycles = 16'd5;
        tick();
        check_all("lower_post", 4'b1111, 4'b0100, 4'b0000, 4'b0000);

        // Simultaneous rise on ch0 and fall on ch3.
        switch_in     = 4'b1110;
        stable_cycles = 16'd1;
        ticks(3);
        check_all("sim_prep", 4'b1110, 4'b0000, 4'b0001, 4'b0000);
        switch_in     = 4'b0111;
        stable_cycles = 16'd4;
        ticks(5);
        check_all("sim_pre", 4'b1110, 4'b0000, 4'b0000, 4'b1001);
        tick();
        check_all("sim_commit", 4'b0111, 4'b0001, 4'b1000, 4'b0000);

        // Reset while ch2 is mid-count.
        switch_in     = 4'b0011;
        stable_cycles = 16'd20;
        ticks(7);
        check_all("rst_pre", 4'b0111, 4'b0000, 4'b0000, 4'b0100);
        reset_n = 1'b0;
        #1;
        check_all("rst_async", INIT, 4'b0000, 4'b0000, 4'b0000);
        model_reset();
        switch_in     = 4'b0001;
        stable_cycles = 16'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("rst_hold", INIT, 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;
        ticks(7);
        check_all("rst_recount", 4'b0101, 4'b0000, 4'b0000, 4'b0100);
        tick();
        check_all("rst_commit", 4'b0001, 4'b0000, 4'b0100, 4'b0000);

        // Randomised traffic against the model, threshold changed now and then.
        begin
            int choices[6];
            choices = '{0, 1, 2, 3, 5, 8};
            for (int c = 0; c < 3000; c++) begin
                if ((c % 150) == 0) stable_cycles = 16'(choices[$urandom_range(0, 5)]);
                for (int ch = 0; ch < N_CH; ch++) begin
                    if ($urandom_range(0, 9) == 0) switch_in[ch] = ~switch_in[ch];
                end
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
